// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe - registered immediate generator between fetch and decode.
//
// Takes one instruction word plus its PC per valid/ready beat. For each beat it
// produces the sign- or zero-extended immediate (I/S/B/U/J, shift amount and,
// optionally, CSR zimm), a class code, and PC+imm. The output is available one
// cycle after acceptance. A 2-entry skid buffer lets in_ready come straight
// from a flop, so there is no combinational path from out_ready to in_ready.
//
// Build option: define IMM_GEN_CSR_EN to decode CSRRWI/CSRRSI/CSRRCI as
// class CSRZ. When it is undefined, those encodings decode as NONE.
//
// Parameters: XLEN (32 or 64), TAG_W (>= 1)
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   in_valid/in_ready              input handshake (in_ready is registered)
//   in_inst, in_pc, in_tag         instruction word, its PC, opaque tag
//   out_valid/out_ready            output handshake
//   out_imm, out_type              extended immediate, class
//                                  (0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 CSRZ)
//   out_pc_imm, out_tag            in_pc + imm (wraps), tag of the beat
//   flush                          discard all held beats and any same-cycle input
//
// state | meaning
// EMPTY | nothing held, out_valid = 0
// ONE   | output register holds a beat
// TWO   | output register and skid register both hold beats, in_ready = 0
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic [XLEN-1:0]  out_pc_imm,
  output logic [TAG_W-1:0] out_tag,
  input  logic             flush
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (TAG_W < 1) begin : g_bad_tag
      $error("imm_gen_pipe: TAG_W must be >= 1");
    end
  endgenerate

  localparam logic [2:0] T_NONE  = 3'd0;
  localparam logic [2:0] T_I     = 3'd1;
  localparam logic [2:0] T_S     = 3'd2;
  localparam logic [2:0] T_B     = 3'd3;
  localparam logic [2:0] T_U     = 3'd4;
  localparam logic [2:0] T_J     = 3'd5;
  localparam logic [2:0] T_SHAMT = 3'd6;
`ifdef IMM_GEN_CSR_EN
  localparam logic [2:0] T_CSRZ  = 3'd7;
`endif

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
`ifdef IMM_GEN_CSR_EN
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
`endif

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state, next_state;

  // ---------------------------------------------------------------- decode
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_type;
  logic [XLEN-1:0] dec_pc_imm;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic signed [11:0] imm_i12;
  logic signed [11:0] imm_s12;
  logic signed [12:0] imm_b13;
  logic signed [31:0] imm_u32;
  logic signed [20:0] imm_j21;
  logic               is_shift;

  assign opcode   = in_inst[6:0];
  assign funct3   = in_inst[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Raw fields are held as signed locals so that the XLEN'() size cast
  // sign-extends from inst[31] for every width, including U on XLEN=64.
  assign imm_i12 = in_inst[31:20];
  assign imm_s12 = {in_inst[31:25], in_inst[11:7]};
  assign imm_b13 = {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u32 = {in_inst[31:12], 12'b0};
  assign imm_j21 = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  always_comb begin
    dec_imm  = '0;
    dec_type = T_NONE;
    case (opcode)
      OP_LOAD, OP_JALR: begin
        dec_imm  = XLEN'(imm_i12);
        dec_type = T_I;
      end
      OP_IMM: begin
        if (is_shift) begin
          // Only the shamt field is used; funct7/funct6 (e.g. the SRAI bit 30) never reaches out_imm.
          dec_imm  = (XLEN == 64) ? XLEN'(in_inst[25:20]) : XLEN'(in_inst[24:20]);
          dec_type = T_SHAMT;
        end else begin
          dec_imm  = XLEN'(imm_i12);
          dec_type = T_I;
        end
      end
      OP_IMM32: begin
        if (XLEN == 64) begin
          if (is_shift) begin
            dec_imm  = XLEN'(in_inst[24:20]);
            dec_type = T_SHAMT;
          end else begin
            dec_imm  = XLEN'(imm_i12);
            dec_type = T_I;
          end
        end
      end
      OP_STORE: begin
        dec_imm  = XLEN'(imm_s12);
        dec_type = T_S;
      end
      OP_BRANCH: begin
        dec_imm  = XLEN'(imm_b13);
        dec_type = T_B;
      end
      OP_LUI, OP_AUIPC: begin
        dec_imm  = XLEN'(imm_u32);
        dec_type = T_U;
      end
      OP_JAL: begin
        dec_imm  = XLEN'(imm_j21);
        dec_type = T_J;
      end
`ifdef IMM_GEN_CSR_EN
      OP_SYSTEM: begin
        if (funct3[2]) begin
          dec_imm  = XLEN'(in_inst[19:15]);
          dec_type = T_CSRZ;
        end
      end
`endif
      default: begin
        dec_imm  = '0;
        dec_type = T_NONE;
      end
    endcase
  end

  assign dec_pc_imm = in_pc + dec_imm;

  // ---------------------------------------------------------------- control
  logic in_xfer, out_xfer;
  logic ld_out_in, ld_out_skid, ld_skid;

  assign out_valid = (state != EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= next_state;
      in_ready <= (next_state != TWO);
    end
  end

  always_comb begin
    next_state  = state;
    ld_out_in   = 1'b0;
    ld_out_skid = 1'b0;
    ld_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          next_state = ONE;
          ld_out_in  = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          ld_out_in = 1'b1;
        end else if (in_xfer) begin
          next_state = TWO;
          ld_skid    = 1'b1;
        end else if (out_xfer) begin
          next_state = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          next_state  = ONE;
          ld_out_skid = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
    if (flush) begin
      next_state  = EMPTY;
      ld_out_in   = 1'b0;
      ld_out_skid = 1'b0;
      ld_skid     = 1'b0;
    end
  end

  // ---------------------------------------------------------------- data
  logic [XLEN-1:0]  skid_imm;
  logic [2:0]       skid_type;
  logic [XLEN-1:0]  skid_pc_imm;
  logic [TAG_W-1:0] skid_tag;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      out_imm     <= '0;
      out_type    <= T_NONE;
      out_pc_imm  <= '0;
      out_tag     <= '0;
      skid_imm    <= '0;
      skid_type   <= T_NONE;
      skid_pc_imm <= '0;
      skid_tag    <= '0;
    end else begin
      if (ld_out_in) begin
        out_imm    <= dec_imm;
        out_type   <= dec_type;
        out_pc_imm <= dec_pc_imm;
        out_tag    <= in_tag;
      end else if (ld_out_skid) begin
        out_imm    <= skid_imm;
        out_type   <= skid_type;
        out_pc_imm <= skid_pc_imm;
        out_tag    <= skid_tag;
      end
      if (ld_skid) begin
        skid_imm    <= dec_imm;
        skid_type   <= dec_type;
        skid_pc_imm <= dec_pc_imm;
        skid_tag    <= in_tag;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance share the stimulus.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [63:0] in_pc64;
  logic [3:0]  in_tag;
  logic        out_ready;
  logic        flush;

  logic        in_ready, out_valid;
  logic [31:0] out_imm, out_pc_imm;
  logic [2:0]  out_type;
  logic [3:0]  out_tag;

  logic        in_ready64, out_valid64;
  logic [63:0] out_imm64, out_pc_imm64;
  logic [2:0]  out_type64;
  logic [3:0]  out_tag64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign in_pc64 = {32'b0, in_pc};

  imm_gen_pipe #(.XLEN(32), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_type(out_type), .out_pc_imm(out_pc_imm), .out_tag(out_tag),
    .flush(flush)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_pc(in_pc64), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_type(out_type64), .out_pc_imm(out_pc_imm64), .out_tag(out_tag64),
    .flush(flush)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with out_ready=1: one beat in, check it one cycle later.
  task automatic beat(input string name, input logic [31:0] inst, input logic [31:0] pc,
                      input logic [3:0] tag, input logic [31:0] e_imm,
                      input logic [2:0] e_type, input logic [31:0] e_pc_imm);
    chk({name, ".in_ready"}, {63'b0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    in_tag   = tag;
    @(negedge clk);
    in_valid = 1'b0;
    chk({name, ".valid"},  {63'b0, out_valid}, 64'd1);
    chk({name, ".imm"},    {32'b0, out_imm}, {32'b0, e_imm});
    chk({name, ".type"},   {61'b0, out_type}, {61'b0, e_type});
    chk({name, ".pc_imm"}, {32'b0, out_pc_imm}, {32'b0, e_pc_imm});
    chk({name, ".tag"},    {60'b0, out_tag}, {60'b0, tag});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; in_tag = '0;
    out_ready = 1'b1; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.valid",  {63'b0, out_valid}, 64'd0);
    chk("rst.ready",  {63'b0, in_ready}, 64'd1);
    chk("rst.imm",    {32'b0, out_imm}, 64'd0);
    chk("rst.type",   {61'b0, out_type}, 64'd0);
    chk("rst.pc_imm", {32'b0, out_pc_imm}, 64'd0);
    chk("rst.tag",    {60'b0, out_tag}, 64'd0);
    chk("rst.valid64", {63'b0, out_valid64}, 64'd0);
    chk("rst.imm64",  out_imm64, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    beat("jal",   32'h8000_00EF, 32'h0000_1000, 4'h1, 32'hFFF0_0000, 3'd5, 32'hFFF0_1000);
    chk("jal.imm64", out_imm64, 64'hFFFF_FFFF_FFF0_0000);
    @(negedge clk);
    chk("jal.drained", {63'b0, out_valid}, 64'd0);
    beat("beq",   32'hFE00_0EE3, 32'h0000_2000, 4'h2, 32'hFFFF_FFFC, 3'd3, 32'h0000_1FFC);
    beat("srai",  32'h4030_D093, 32'h0000_0100, 4'h3, 32'h0000_0003, 3'd6, 32'h0000_0103);
    beat("addi",  32'hFFF0_0093, 32'h0000_0010, 4'h4, 32'hFFFF_FFFF, 3'd1, 32'h0000_000F);
    beat("sw",    32'h0011_2623, 32'h0000_0020, 4'h5, 32'h0000_000C, 3'd2, 32'h0000_002C);
    beat("lui",   32'h8000_0037, 32'h0000_0000, 4'h6, 32'h8000_0000, 3'd4, 32'h8000_0000);
    chk("lui.imm64",  out_imm64, 64'hFFFF_FFFF_8000_0000);
    chk("lui.type64", {61'b0, out_type64}, 64'd4);
    beat("auipc", 32'h0000_1017, 32'hFFFF_F800, 4'h7, 32'h0000_1000, 3'd4, 32'h0000_0800);
    beat("slli",  32'h03F0_9093, 32'h0000_0000, 4'h8, 32'h0000_001F, 3'd6, 32'h0000_001F);
    chk("slli.imm64", out_imm64, 64'd63);
    beat("rtype", 32'h0000_0033, 32'h0000_4444, 4'h9, 32'h0000_0000, 3'd0, 32'h0000_4444);
    beat("addiw", 32'hFFF0_009B, 32'h0000_0040, 4'hA, 32'h0000_0000, 3'd0, 32'h0000_0040);
    chk("addiw.imm64",  out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addiw.type64", {61'b0, out_type64}, 64'd1);
`ifdef IMM_GEN_CSR_EN
    beat("csrrwi", 32'h000F_D073, 32'h0000_0000, 4'hB, 32'h0000_001F, 3'd7, 32'h0000_001F);
`else
    beat("csrrwi", 32'h000F_D073, 32'h0000_0000, 4'hB, 32'h0000_0000, 3'd0, 32'h0000_0000);
`endif
    @(negedge clk);

    // Back-pressure: three beats offered, two held, then released in order.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h0010_0093; in_pc = 32'h0; in_tag = 4'hA;
    @(negedge clk);
    chk("bp.ready1", {63'b0, in_ready}, 64'd1);
    in_inst = 32'h0020_0093; in_tag = 4'hB;
    @(negedge clk);
    in_inst = 32'h0030_0093; in_tag = 4'hC;
    chk("bp.ready2", {63'b0, in_ready}, 64'd0);
    chk("bp.head",   {60'b0, out_tag}, 64'hA);
    @(negedge clk);
    chk("bp.stall_ready", {63'b0, in_ready}, 64'd0);
    chk("bp.stall_tag",   {60'b0, out_tag}, 64'hA);
    chk("bp.stall_imm",   {32'b0, out_imm}, 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp.second_tag", {60'b0, out_tag}, 64'hB);
    chk("bp.second_imm", {32'b0, out_imm}, 64'd2);
    chk("bp.ready3",     {63'b0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp.third_tag", {60'b0, out_tag}, 64'hC);
    chk("bp.third_imm", {32'b0, out_imm}, 64'd3);
    @(negedge clk);
    chk("bp.empty", {63'b0, out_valid}, 64'd0);

    // Flush while full with a beat offered.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h0040_0093; in_tag = 4'h1;
    @(negedge clk);
    in_tag = 4'h2;
    @(negedge clk);
    chk("fl.full", {63'b0, in_ready}, 64'd0);
    in_tag = 4'h3;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl.valid", {63'b0, out_valid}, 64'd0);
    chk("fl.ready", {63'b0, in_ready}, 64'd1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("fl.nothing", {63'b0, out_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
